// File: rtl/binary_pkg.sv
// Shared defaults and state encoding for the binary frame packer.
package binary_pkg;

  localparam int unsigned FRAME_LEN_DEF = 64;
  localparam int unsigned WORD_W_DEF    = 8;
  localparam int unsigned CNT_W_DEF     = 7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PACK = 1'b1;

endpackage

// File: rtl/bit_pack_shift.sv
// Shift register that packs one decision bit per enable, LSB first, and flags
// word completion either on a full word or on an external flush (frame end).
module bit_pack_shift
  import binary_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iEN,
  input  logic              iBIT,
  input  logic              iFLUSH,
  output logic [WORD_W-1:0] oWORD_c,
  output logic              oDONE_c
);

  localparam int unsigned IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] shReg;
  logic [IDX_W-1:0]  bitIdx;
  logic [WORD_W-1:0] wordNext;
  logic              wordFull;

  // Word as it would look with the incoming bit included; upper bits stay zero.
  always_comb begin
    wordNext         = shReg;
    wordNext[bitIdx] = iBIT;
    wordFull         = (bitIdx == IDX_W'(WORD_W - 1)) | iFLUSH;
    oWORD_c          = wordNext;
    oDONE_c          = iEN & wordFull;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      shReg  <= '0;
      bitIdx <= '0;
    end else if (iEN) begin
      if (wordFull) begin
        shReg  <= '0;
        bitIdx <= '0;
      end else begin
        shReg  <= wordNext;
        bitIdx <= bitIdx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/binary_frame_packer.sv
// Packs the comparator decision stream into words per STFT frame, with frame
// hit count, valid/ready output register and sticky overflow flag.
module binary_frame_packer
  import binary_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iEN,
  input  logic              iDATA,
  input  logic              iCLR_OVF,
  output logic [WORD_W-1:0] oDATA,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oLAST,
  output logic [CNT_W-1:0]  oCNT,
  output logic              oFRAME_DONE,
  output logic              oOVF
);

  logic [0:0]        state;
  logic [0:0]        stateNext;
  logic [CNT_W-1:0]  binIdx;
  logic [CNT_W-1:0]  hitCnt;
  logic [CNT_W-1:0]  hitNext;
  logic              lastBin;
  logic              frameEnd;
  logic [WORD_W-1:0] word_c;
  logic              wordDone_c;
  logic              ovfEvent;

  assign lastBin  = (binIdx == CNT_W'(FRAME_LEN - 1));
  assign frameEnd = iEN & lastBin;
  assign hitNext  = hitCnt + CNT_W'(iDATA);
  // A completed word is lost only if the held word is not leaving this cycle.
  assign ovfEvent = wordDone_c & oVALID & ~iREADY;

  bit_pack_shift #(
    .WORD_W (WORD_W)
  ) uShift (
    .iCLK    (iCLK),
    .iRSTn   (iRSTn),
    .iEN     (iEN),
    .iBIT    (iDATA),
    .iFLUSH  (lastBin),
    .oWORD_c (word_c),
    .oDONE_c (wordDone_c)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (iEN) stateNext = ST_PACK;
      ST_PACK: if (frameEnd) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Frame position and hit accounting run regardless of output back-pressure.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      binIdx      <= '0;
      hitCnt      <= '0;
      oCNT        <= '0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oFRAME_DONE <= frameEnd;
      if (iEN) begin
        if (lastBin) begin
          binIdx <= '0;
          hitCnt <= '0;
          oCNT   <= hitNext;
        end else begin
          binIdx <= binIdx + CNT_W'(1);
          hitCnt <= hitNext;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oDATA  <= '0;
      oVALID <= 1'b0;
      oLAST  <= 1'b0;
    end else if (wordDone_c && !ovfEvent) begin
      oDATA  <= word_c;
      oVALID <= 1'b1;
      oLAST  <= lastBin;
    end else if (oVALID && iREADY) begin
      oVALID <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oOVF <= 1'b0;
    end else if (ovfEvent) begin
      oOVF <= 1'b1;
    end else if (iCLR_OVF) begin
      oOVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_frame_packer.sv
// Directed bench: table of full frames, plus reset, overflow, gap and short-frame sequences.
module tb_binary_frame_packer;

  logic       clk = 1'b0;
  logic       rstN, en, dat, clrOvf, ready;
  logic [7:0] oData;
  logic       oValid, oLast, oFrameDone, oOvf;
  logic [6:0] oCnt;

  logic       enB, datB, clrOvfB, readyB;
  logic [7:0] oDataB;
  logic       oValidB, oLastB, oFrameDoneB, oOvfB;
  logic [4:0] oCntB;

  always #5 clk = ~clk;

  binary_frame_packer uDut (
    .iCLK(clk), .iRSTn(rstN), .iEN(en), .iDATA(dat), .iCLR_OVF(clrOvf),
    .oDATA(oData), .oVALID(oValid), .iREADY(ready), .oLAST(oLast),
    .oCNT(oCnt), .oFRAME_DONE(oFrameDone), .oOVF(oOvf)
  );

  binary_frame_packer #(.FRAME_LEN(12), .WORD_W(8), .CNT_W(5)) uDutB (
    .iCLK(clk), .iRSTn(rstN), .iEN(enB), .iDATA(datB), .iCLR_OVF(clrOvfB),
    .oDATA(oDataB), .oVALID(oValidB), .iREADY(readyB), .oLAST(oLastB),
    .oCNT(oCntB), .oFRAME_DONE(oFrameDoneB), .oOVF(oOvfB)
  );

  logic [8:0] qA[$];
  logic [8:0] qB[$];
  int         doneA = 0, doneB = 0;
  logic [6:0] cntA = '0;
  logic [4:0] cntB = '0;

  // Consumer side: words are taken at the edge where valid and ready are both high.
  always @(posedge clk) begin
    if (oValid && ready) qA.push_back({oLast, oData});
    if (oValidB && readyB) qB.push_back({oLastB, oDataB});
    if (oFrameDone) begin doneA <= doneA + 1; cntA <= oCnt; end
    if (oFrameDoneB) begin doneB <= doneB + 1; cntB <= oCntB; end
  end

  int passed = 0, total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    en = 1'b1;
    dat = b;
    tick();
    en = 1'b0;
  endtask

  task automatic sendBits(input logic [63:0] bits, input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      sendBit(bits[i]);
    end
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    #12;
    rstN = 1'b1;
    tick();
  endtask

  // Checks 8 delivered words, oLAST only on the last, and one frame-done pulse.
  task automatic checkFrame(input string nm, input logic [63:0] words, input logic [6:0] cnt, input int doneBase);
    logic [8:0] w;
    int n;
    repeat (3) tick();
    n = qA.size();
    check({nm, " nwords"}, 64'(n), 64'd8);
    for (int k = 0; k < 8 && k < n; k++) begin
      w = qA.pop_front();
      check($sformatf("%s word%0d", nm, k), 64'(w), 64'({(k == 7), words[8*k +: 8]}));
    end
    check({nm, " doneCnt"}, 64'(doneA - doneBase), 64'd1);
    check({nm, " oCNT"}, 64'(cntA), 64'(cnt));
  endtask

  typedef struct {
    string      name;
    logic [63:0] bits;
    logic [63:0] words;
    logic [6:0]  cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] alt;
    int base;
    vecs[0] = '{"zeros", 64'h0000000000000000, 64'h0000000000000000, 7'd0};
    vecs[1] = '{"alt",   64'h5555555555555555, 64'h5555555555555555, 7'd32};
    vecs[2] = '{"ones",  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 7'd64};
    vecs[3] = '{"lowb",  64'h00000000000000FF, 64'h00000000000000FF, 7'd8};
    vecs[4] = '{"ends",  64'h8000000000000001, 64'h8000000000000001, 7'd2};
    vecs[5] = '{"nib",   64'hF0F0F0F0F0F0F0F0, 64'hF0F0F0F0F0F0F0F0, 7'd32};
    alt = 64'h5555555555555555;

    rstN = 1'b0; en = 0; dat = 0; clrOvf = 0; ready = 1;
    enB = 0; datB = 0; clrOvfB = 0; readyB = 1;
    #12;
    check("reset outputs", 64'({oData, oValid, oLast, oCnt, oFrameDone, oOvf}), 64'd0);
    rstN = 1'b1;
    tick();

    // Reset in the middle of a frame clears everything asynchronously.
    sendBits(alt, 0, 36, 1'b0);
    rstN = 1'b0;
    #1;
    check("midreset outputs", 64'({oData, oValid, oLast, oCnt, oFrameDone, oOvf}), 64'd0);
    #10;
    rstN = 1'b1;
    tick();
    qA.delete();

    for (int v = 0; v < 6; v++) begin
      base = doneA;
      sendBits(vecs[v].bits, 0, 63, 1'b0);
      checkFrame(vecs[v].name, vecs[v].words, vecs[v].cnt, base);
    end

    // Gapped input over two frames must give the same words as gap-free input.
    base = doneA;
    sendBits(vecs[1].bits, 0, 63, 1'b1);
    checkFrame("gap1", vecs[1].words, vecs[1].cnt, base);
    base = doneA;
    sendBits(vecs[4].bits, 0, 63, 1'b1);
    checkFrame("gap2", vecs[4].words, vecs[4].cnt, base);

    // Short frame on the 12-bit instance: 0xFF then zero-padded 0x0F with oLAST.
    for (int i = 0; i < 12; i++) begin
      enB = 1'b1; datB = 1'b1; tick();
    end
    enB = 1'b0;
    repeat (3) tick();
    check("short nwords", 64'(qB.size()), 64'd2);
    if (qB.size() >= 2) begin
      check("short word0", 64'(qB[0]), 64'h0FF);
      check("short word1", 64'(qB[1]), 64'h10F);
    end
    check("short doneCnt", 64'(doneB), 64'd1);
    check("short oCNT", 64'(cntB), 64'd12);

    // Back-pressure: first word held, second word overflows.
    applyReset();
    qA.delete();
    base = doneA;
    ready = 1'b0;
    sendBits(alt, 0, 7, 1'b0);
    check("bp held valid", 64'({oValid, oData, oOvf}), 64'({1'b1, 8'h55, 1'b0}));
    sendBits(alt, 8, 15, 1'b0);
    check("bp ovf set", 64'({oValid, oData, oOvf}), 64'({1'b1, 8'h55, 1'b1}));
    clrOvf = 1'b1; tick(); clrOvf = 1'b0;
    check("bp ovf clear", 64'(oOvf), 64'd0);
    sendBits(alt, 16, 22, 1'b0);
    clrOvf = 1'b1;
    sendBit(alt[23]);
    clrOvf = 1'b0;
    check("bp set wins", 64'(oOvf), 64'd1);
    ready = 1'b1;
    tick();
    check("bp delivered n", 64'(qA.size()), 64'd1);
    if (qA.size() >= 1) check("bp delivered word", 64'(qA[0]), 64'h055);
    sendBits(alt, 24, 63, 1'b0);
    repeat (3) tick();
    check("bp doneCnt", 64'(doneA - base), 64'd1);
    check("bp oCNT", 64'(cntA), 64'd32);
    check("bp ovf sticky", 64'(oOvf), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
